// File: rtl/reg_univ_pkg.sv
// Shared encodings for the universal shift register: command modes and FSM states.
package reg_univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the modes that take a step count (SHL..ASR).
  function automatic logic is_shift(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

endpackage

// File: rtl/reg_univ_shift.sv
// Single-step next-value datapath for the universal shift register.
module reg_univ_shift
  import reg_univ_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_next
);

  // Next register value for one clock step of the selected mode.
  always_comb begin
    q_next = q;
    unique case (mode_e'(mode))
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = par_in;
      MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
      MODE_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/reg_univ_param.sv
// Parametrised universal shift register with multi-step start/busy/done commands.
// One bit position per clock; serial outputs expose both ends for chaining.
module reg_univ_param
  import reg_univ_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] steps,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] q_step;

  // The acceptance edge acts on the live mode; later edges use the latched one.
  assign step_mode = (state_q == ST_IDLE) ? mode : mode_q;

  reg_univ_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .q        (q_q),
    .mode     (step_mode),
    .par_in   (par_in),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .q_next   (q_step)
  );

  // Next-state, step counter and register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (is_shift(mode)) begin
            if (steps == '0) begin
              // Zero-step shift behaves like HOLD.
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              q_d     = q_step;
              cnt_d   = steps - CNT_W'(1);
              state_d = (steps == CNT_W'(1)) ? ST_DONE : ST_RUN;
            end
          end else begin
            q_d     = q_step;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        q_d   = q_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
    end
  end

  assign q         = q_q;
  assign ser_out_l = q_q[WIDTH-1];
  assign ser_out_r = q_q[0];
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_univ_param.sv
// Directed bench for reg_univ_param: vector table plus hand-written multi-cycle sequences.
module tb_reg_univ_param;
  import reg_univ_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] par_in;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fails  = 0;

  reg_univ_param #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .steps     (steps),
    .par_in    (par_in),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] md;
    logic [3:0] st;
    logic [7:0] par;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    int         exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command with a single-cycle start; count busy/done cycles until back in IDLE.
  task automatic run_cmd(input logic [2:0] md, input logic [3:0] st, input logic [7:0] par,
                         input logic sl, input logic sr,
                         output int busy_cnt, output int done_cnt, output bit timeout);
    @(negedge clk);
    mode     = md;
    steps    = st;
    par_in   = par;
    ser_in_l = sl;
    ser_in_r = sr;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    timeout  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        timeout = 1'b0;
        @(negedge clk);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        break;
      end
    end
  endtask

  initial begin
    int  bc, dc;
    bit  to;
    logic [7:0] eq;

    vecs[0]  = '{MODE_LOAD, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 0};
    vecs[1]  = '{MODE_LOAD, 4'd0,  8'h96, 1'b0, 1'b0, 8'h96, 0};
    vecs[2]  = '{MODE_ASR,  4'd2,  8'h00, 1'b0, 1'b0, 8'hE5, 1};
    vecs[3]  = '{MODE_CLR,  4'd5,  8'hFF, 1'b0, 1'b0, 8'h00, 0};
    vecs[4]  = '{MODE_LOAD, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C, 0};
    vecs[5]  = '{MODE_SHL,  4'd0,  8'h00, 1'b1, 1'b1, 8'h3C, 0};
    vecs[6]  = '{MODE_ROR,  4'd8,  8'h00, 1'b0, 1'b0, 8'h3C, 7};
    vecs[7]  = '{MODE_ROR,  4'd9,  8'h00, 1'b0, 1'b0, 8'h1E, 8};
    vecs[8]  = '{MODE_SHL,  4'd3,  8'h00, 1'b0, 1'b1, 8'hF7, 2};
    vecs[9]  = '{MODE_HOLD, 4'd7,  8'h00, 1'b0, 1'b0, 8'hF7, 0};
    vecs[10] = '{MODE_ASR,  4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 14};
    vecs[11] = '{MODE_LOAD, 4'd0,  8'h40, 1'b0, 1'b0, 8'h40, 0};
    vecs[12] = '{MODE_ASR,  4'd15, 8'h00, 1'b1, 1'b1, 8'h00, 14};
    vecs[13] = '{MODE_ROL,  4'd1,  8'h00, 1'b0, 1'b0, 8'h00, 0};

    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = MODE_HOLD;
    steps    = '0;
    par_in   = '0;
    ser_in_l = 1'b0;
    ser_in_r = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // ROL 0xA5 x3, checked edge by edge.
    run_cmd(MODE_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, bc, dc, to);
    check("rol_pre_q", 32'(q), 32'hA5);
    @(negedge clk);
    mode  = MODE_ROL;
    steps = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rol_e0_q", 32'(q), 32'h4B);
    check("rol_e0_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("rol_e1_q", 32'(q), 32'h96);
    check("rol_e1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("rol_e2_q", 32'(q), 32'h2D);
    check("rol_e2_done", 32'(done), 32'h1);
    check("rol_e2_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("rol_idle_done", 32'(done), 32'h0);

    // Table of single commands, each chained from the previous register value.
    for (int i = 0; i < 14; i++) begin
      run_cmd(vecs[i].md, vecs[i].st, vecs[i].par, vecs[i].sl, vecs[i].sr, bc, dc, to);
      eq = vecs[i].exp_q;
      check($sformatf("vec%0d_timeout", i), 32'(to), 32'h0);
      check($sformatf("vec%0d_q", i), 32'(q), 32'(eq));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done_cycles", i), 32'(dc), 32'h1);
      check($sformatf("vec%0d_ser_out_l", i), 32'(ser_out_l), 32'(eq[7]));
      check($sformatf("vec%0d_ser_out_r", i), 32'(ser_out_r), 32'(eq[0]));
    end

    // SHR x4 from zero with ser_in_l=1; a CLR start during RUN must be ignored.
    run_cmd(MODE_CLR, 4'd0, 8'h00, 1'b0, 1'b0, bc, dc, to);
    @(negedge clk);
    mode     = MODE_SHR;
    steps    = 4'd4;
    ser_in_l = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    mode  = MODE_CLR;
    steps = 4'd0;
    to    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    check("shr_timeout", 32'(to), 32'h0);
    check("shr_done_q", 32'(q), 32'hF0);
    @(negedge clk);
    @(negedge clk);
    check("shr_after_q", 32'(q), 32'hF0);
    check("shr_after_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a ROL x5.
    run_cmd(MODE_LOAD, 4'd0, 8'h0F, 1'b0, 1'b0, bc, dc, to);
    @(negedge clk);
    mode  = MODE_ROL;
    steps = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    check("midrst_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_q", 32'(q), 32'h0);
    check("postrst_busy", 32'(busy), 32'h0);
    check("postrst_done", 32'(done), 32'h0);
    run_cmd(MODE_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0, bc, dc, to);
    check("postrst_load_q", 32'(q), 32'h5A);
    check("postrst_load_done", 32'(dc), 32'h1);
    check("postrst_load_busy", 32'(bc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_univ_param.md
Name: reg_univ_param

Overview:
- Parametrised universal shift register: WIDTH-bit register with parallel load, clear, logical/arithmetic shifts and rotates.
- Performs multi-step shift commands, one bit position per clock, with a start/busy/done handshake.
- Next-generation flip-flop register building block; drives serial outputs at both ends for chaining to other registers.

Parameters:
- WIDTH, 8: register width in bits, minimum 2.
- CNT_W, 4: width of the step count; maximum steps per command is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  3  operation: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
- steps  in  CNT_W  number of single-bit shifts for modes 2-6.
- par_in  in  WIDTH  parallel load data.
- ser_in_l  in  1  serial fill bit entering the MSB on SHR.
- ser_in_r  in  1  serial fill bit entering the LSB on SHL.
- q  out  WIDTH  register contents.
- ser_out_l  out  1  equals q[WIDTH-1], combinational from q.
- ser_out_r  out  1  equals q[0], combinational from q.
- busy  out  1  high while a multi-step command is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0, takes effect immediately, including mid-command):
  - q=0, busy=0, done=0, cnt=0, state=IDLE.
- State machine: IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE). Both are registered state decodes.
- Command acceptance: at the edge E0 where state==IDLE and start=1:
  - mode and steps are latched.
  - par_in is sampled only at E0.
- Single-edge operations (HOLD, LOAD, CLR, or any shift mode with steps=0):
  - At E0: LOAD sets q=par_in; CLR sets q=0; HOLD and steps=0 leave q unchanged.
  - State goes to DONE; busy is never asserted.
- Shift modes with steps=N≥1:
  - First shift is applied at E0; cnt<=N-1.
  - If N=1, state goes to DONE; otherwise state goes to RUN.
  - In RUN, each edge applies one shift and decrements cnt. The edge where cnt==1 applies the last shift and moves to DONE.
  - Exactly N shifts occur on N consecutive edges E0..E(N-1).
  - busy is high for N-1 cycles; done is high for the cycle after E(N-1).
- DONE always returns to IDLE on the next edge. start is ignored in DONE.
  - A new command therefore needs start held or re-asserted while in IDLE.
- start, mode, steps and par_in changes during RUN/DONE are ignored; the latched values govern.
- ser_in_l and ser_in_r are sampled live at every shift edge.
- Shift definitions (W=WIDTH):
  - SHL: q<={q[W-2:0],ser_in_r}
  - SHR: q<={ser_in_l,q[W-1:1]}
  - ROL: q<={q[W-2:0],q[W-1]}
  - ROR: q<={q[0],q[W-1:1]}
  - ASR: q<={q[W-1],q[W-1:1]}
- steps>WIDTH is legal:
  - Rotates wrap modulo WIDTH.
  - SHL/SHR keep filling from the serial inputs.
  - ASR saturates to all-sign.
- All registers use nonblocking assignment. The next-q computation is purely combinational from the latched mode, q and the serial inputs.

Decomposition:
- Package reg_univ_pkg:
  - mode encodings (MODE_HOLD..MODE_CLR, 3 bits).
  - state encoding (ST_IDLE, ST_RUN, ST_DONE, 2 bits).
- One combinational sub-module, reg_univ_shift:
  - inputs: q, mode, par_in, ser_in_l, ser_in_r.
  - output: q_next for a single step.
  - The top holds the FSM, step counter, latched mode and the q register.

Test Plan:
- Reset mid-command: ROL steps=5 running, pull rst_n=0 between edges -> q=0x00, busy=0, done=0 immediately, without waiting for a clock edge; after release, state is IDLE.
- LOAD: par_in=0xA5, start 1 cycle -> q=0xA5 after E0; done=1 for exactly the next cycle; busy stays 0.
- ROL from 0xA5, steps=3 -> q sequence 0x4B, 0x96, 0x2D on E0..E2; busy=1 for 2 cycles; done=1 for 1 cycle after E2.
- ASR from 0x96, steps=2 -> 0xCB then 0xE5; ser_out_l=1 and ser_out_r=1 at the end.
- SHR from 0x00, steps=4, ser_in_l=1 -> 0xF0. During RUN assert start with mode=CLR -> ignored, final q=0xF0.
- Boundaries:
  - SHL steps=0 on 0x3C -> q stays 0x3C, done after 1 cycle.
  - ROR steps=8 on 0x3C -> 0x3C.
  - ROR steps=9 on 0x3C -> 0x1E.
